// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - command, register-file read port and word stream of the dump reader
interface regfile_dump_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              i_start;
    logic [ADDR_W-1:0] i_first_addr;
    logic [ADDR_W-1:0] i_last_addr;
    logic [ADDR_W-1:0] o_raddr;
    logic [DATA_W-1:0] i_rdata;
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] o_addr;
    logic              o_valid;
    logic              i_ready;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_xor;

    modport master (
        input  i_start, i_first_addr, i_last_addr, i_rdata, i_ready,
        output o_raddr, o_data, o_addr, o_valid, o_busy, o_done, o_xor
    );

    modport slave (
        output i_start, i_first_addr, i_last_addr, i_rdata, i_ready,
        input  o_raddr, o_data, o_addr, o_valid, o_busy, o_done, o_xor
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register address range and streams each word with its address plus an XOR checksum
module regfile_dump_reader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    regfile_dump_reader_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] cur_inc;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [DATA_W-1:0] xor_q;
    logic              accept;
    logic              at_last;

    assign accept  = valid_q && bus.i_ready;
    assign at_last = (cur == last);
    // Explicit wrap keeps the walk correct even when NUM_REGS is not a power of two.
    assign cur_inc = (cur == ADDR_W'(NUM_REGS - 1)) ? '0 : cur + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.i_start) state_nxt = S_READ;
            S_READ: state_nxt = S_HOLD;
            S_HOLD: if (accept) state_nxt = at_last ? S_DONE : S_READ;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur     <= '0;
            last    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            xor_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        cur   <= bus.i_first_addr;
                        last  <= bus.i_last_addr;
                        xor_q <= '0;
                    end
                end
                S_READ: begin
                    data_q  <= bus.i_rdata;
                    addr_q  <= cur;
                    valid_q <= 1'b1;
                end
                S_HOLD: begin
                    if (accept) begin
                        xor_q   <= xor_q ^ data_q;
                        valid_q <= 1'b0;
                        if (!at_last) cur <= cur_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // The read port is always driven by cur; reads are side-effect free, so non-READ cycles are harmless.
    assign bus.o_raddr = cur;
    assign bus.o_data  = data_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = (state != S_IDLE);
    assign bus.o_done  = (state == S_DONE);
    assign bus.o_xor   = xor_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed and randomized checks of regfile_dump_reader against an address-range model
module tb_regfile_dump_reader;
    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    regfile_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    assign bus.i_rdata = 32'hA5A50000 | 32'(bus.o_raddr);

    function automatic logic [31:0] exp_word(input int a);
        return 32'hA5A50000 | 32'(a % 32);
    endfunction

    function automatic int word_count(input int f, input int l);
        return ((l - f) + 32) % 32 + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic run_walk(input string name, input int f, input int l, input int ready_pct,
                            input int stall_first, input bit busy_start, input bit start_in_done);
        int          n;
        logic [31:0] exp_xor;
        int          idx;
        int          cyc;
        int          first_valid;
        int          early_done;
        int          stalls;
        bit          rdy;
        n           = word_count(f, l);
        exp_xor     = '0;
        idx         = 0;
        cyc         = 0;
        first_valid = -1;
        early_done  = 0;
        stalls      = 0;
        for (int k = 0; k < n; k++) exp_xor ^= exp_word(f + k);

        bus.i_first_addr = 5'(f);
        bus.i_last_addr  = 5'(l);
        bus.i_start      = 1'b1;
        bus.i_ready      = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check({name, "_busy_after_start"}, 32'(bus.o_busy), 32'd1);

        while (idx < n && cyc < 400) begin
            if (busy_start && cyc == 3) begin
                bus.i_start      = 1'b1;
                bus.i_first_addr = 5'd9;
                bus.i_last_addr  = 5'd9;
            end else begin
                bus.i_start = 1'b0;
            end
            rdy = ($urandom_range(99) < ready_pct);
            if (bus.o_valid === 1'b1 && idx == 0 && stalls < stall_first) begin
                rdy = 1'b0;
                stalls++;
            end
            bus.i_ready = rdy;
            if (bus.o_done !== 1'b0) early_done++;
            if (bus.o_valid === 1'b1) begin
                if (first_valid < 0) first_valid = cyc;
                check($sformatf("%s_data%0d", name, idx), bus.o_data, exp_word(f + idx));
                check($sformatf("%s_addr%0d", name, idx), 32'(bus.o_addr), 32'((f + idx) % 32));
                if (rdy) idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end

        bus.i_ready = 1'b0;
        bus.i_start = start_in_done;
        check({name, "_word_count"}, idx, n);
        check({name, "_first_latency"}, first_valid, 1);
        check({name, "_no_early_done"}, early_done, 0);
        if (ready_pct >= 100) check({name, "_cycles"}, cyc, 2 * n + stall_first);
        check({name, "_done_pulse"}, 32'(bus.o_done), 32'd1);
        check({name, "_busy_in_done"}, 32'(bus.o_busy), 32'd1);
        check({name, "_xor"}, bus.o_xor, exp_xor);
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check({name, "_done_cleared"}, 32'(bus.o_done), 32'd0);
        check({name, "_idle"}, 32'(bus.o_busy), 32'd0);
        check({name, "_xor_held"}, bus.o_xor, exp_xor);
    endtask

    initial begin
        int cnt;
        rst              = 1'b1;
        bus.i_start      = 1'b0;
        bus.i_first_addr = '0;
        bus.i_last_addr  = '0;
        bus.i_ready      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_xor", bus.o_xor, 32'd0);
        check("rst_data", bus.o_data, 32'd0);
        check("rst_addr", 32'(bus.o_addr), 32'd0);
        check("rst_raddr", 32'(bus.o_raddr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_walk("single", 5, 5, 100, 0, 1'b0, 1'b0);
        run_walk("full", 0, 31, 100, 0, 1'b0, 1'b0);
        run_walk("wrap", 30, 1, 100, 0, 1'b0, 1'b0);
        run_walk("stall", 2, 3, 100, 7, 1'b0, 1'b0);
        run_walk("busy_start", 0, 3, 100, 0, 1'b1, 1'b0);
        run_walk("done_start", 12, 14, 100, 0, 1'b0, 1'b1);
        run_walk("full_wrap", 17, 16, 70, 0, 1'b0, 1'b0);

        bus.i_first_addr = 5'd0;
        bus.i_last_addr  = 5'd7;
        bus.i_start      = 1'b1;
        bus.i_ready      = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        cnt = 0;
        while (!(bus.o_valid === 1'b1 && bus.o_addr == 5'd2) && cnt < 50) begin
            bus.i_ready = 1'b1;
            @(posedge clk); #1;
            cnt++;
        end
        bus.i_ready = 1'b0;
        check("midrst_reached_word3", 32'(cnt < 50), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.o_valid), 32'd0);
        check("midrst_busy", 32'(bus.o_busy), 32'd0);
        check("midrst_xor", bus.o_xor, 32'd0);
        check("midrst_done", 32'(bus.o_done), 32'd0);
        @(posedge clk); #1;
        check("midrst_done_after", 32'(bus.o_done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_walk("after_rst", 7, 7, 100, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_walk($sformatf("rand%0d", r), int'($urandom_range(31)), int'($urandom_range(31)),
                     60, 0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
